noc_output_port_arb: RTL and testbench

- Parametrised output-port unit for the mesh router: packet-locked round-robin arbiter, crossbar mux and registered output stage with RTS/DCTS handshake, merged into one block.
- One instance per router output port. It replaces the fixed 5-input arbiter/xbar/output_buffer chain.
- Adds the following over that chain:
  - configurable input count and data width;
  - per-instance U-turn masking;
  - packet-length counter with early tail release;
  - malformed-packet error flag.

---
 rtl/noc_output_port_arb_pkg.sv | 26 ++
 rtl/noc_output_port_arb_if.sv | 36 +++
 rtl/noc_rr_pick.sv | 34 +++
 rtl/noc_output_port_arb.sv | 153 +++++++++++++++
 tb/tb_noc_output_port_arb.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/noc_output_port_arb_pkg.sv
// Shared definitions for the router output-port arbiter.
//   - flit type codes carried in the top three bits of every flit
//   - field offsets, given as distance below DATA_WIDTH so that they hold for
//     any flit width: type MSB = DATA_WIDTH-TYPE_MSB, length MSB = DATA_WIDTH-LEN_MSB
//   - FSM state encoding and an index-width helper
package noc_output_port_arb_pkg;

  localparam int TYPE_W   = 3;
  localparam int TYPE_MSB = 1;
  localparam int LEN_MSB  = 4;

  localparam logic [TYPE_W-1:0] FT_HEADER = 3'b001;
  localparam logic [TYPE_W-1:0] FT_BODY   = 3'b010;
  localparam logic [TYPE_W-1:0] FT_TAIL   = 3'b100;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

  // Index width that stays at least one bit for a single-input port.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/noc_output_port_arb_if.sv
// Bundle between one router output port and its environment.
//   Input side : req, in_valid, in_data (flattened FIFO heads), rd_en (pop)
//   Output side: DCTS (downstream ready), TX, RTS
//   Status     : busy, owner, pkt_err
// slave  - the arbiter block
// master - upstream FIFOs / downstream link driving and observing the port
interface noc_output_port_arb_if
  import noc_output_port_arb_pkg::*;
#(
  parameter int NUM_IN     = 5,
  parameter int DATA_WIDTH = 32
);
  localparam int OWN_W = idx_width(NUM_IN);

  logic [NUM_IN-1:0]            req;
  logic [NUM_IN-1:0]            in_valid;
  logic [NUM_IN*DATA_WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]            rd_en;
  logic                         DCTS;
  logic [DATA_WIDTH-1:0]        TX;
  logic                         RTS;
  logic                         busy;
  logic [OWN_W-1:0]             owner;
  logic                         pkt_err;

  modport slave (
    input  req, in_valid, in_data, DCTS,
    output rd_en, TX, RTS, busy, owner, pkt_err
  );

  modport master (
    output req, in_valid, in_data, DCTS,
    input  rd_en, TX, RTS, busy, owner, pkt_err
  );

endinterface

// File: rtl/noc_rr_pick.sv
// Combinational round-robin selector.
//   i_req : request vector
//   i_ptr : index of the last winner; scanning starts at i_ptr+1 and wraps
//   o_gnt : one-hot grant (all zero when nothing is requested)
//   o_idx : index of the granted requester (0 when nothing is requested)
module noc_rr_pick #(
  parameter int N     = 5,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt,
  output logic [IDX_W-1:0] o_idx
);

  logic             w_found;
  logic [IDX_W-1:0] w_k;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_k     = '0;
    for (int i = 1; i <= N; i++) begin
      w_k = IDX_W'((int'(i_ptr) + i) % N);
      if (!w_found && i_req[w_k]) begin
        w_found    = 1'b1;
        o_gnt[w_k] = 1'b1;
        o_idx      = w_k;
      end
    end
  end

endmodule

// File: rtl/noc_output_port_arb.sv
// Router output port: packet-locked round-robin arbiter, crossbar mux and
// registered output stage with RTS/DCTS handshake.
//   clk, rst : clock, synchronous active-low reset
//   bus      : slave modport (req/in_valid/in_data/rd_en from the input FIFOs,
//              DCTS/TX/RTS to the downstream link, busy/owner/pkt_err status)
// A packet is locked to the output from its header until the tail, or until
// the header length has been sent, whichever comes first.
module noc_output_port_arb
  import noc_output_port_arb_pkg::*;
#(
  parameter int                NUM_IN     = 5,
  parameter int                DATA_WIDTH = 32,
  parameter int                LEN_WIDTH  = 12,
  parameter logic [NUM_IN-1:0] IN_MASK    = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  noc_output_port_arb_if.slave  bus
);

  localparam int                   IDX_W   = idx_width(NUM_IN);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  state_e                r_state;
  state_e                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_tx;
  logic                  r_rts;
  logic                  r_busy;
  logic                  r_err;
  logic                  r_first;
  logic [IDX_W-1:0]      r_owner;
  logic [IDX_W-1:0]      r_ptr;
  logic [LEN_WIDTH-1:0]  r_cnt;

  logic [DATA_WIDTH-1:0] w_flit [NUM_IN];
  logic [NUM_IN-1:0]     w_is_hdr;
  logic [NUM_IN-1:0]     w_elig;
  logic [NUM_IN-1:0]     w_gnt;
  logic [NUM_IN-1:0]     w_rd_en;
  logic [IDX_W-1:0]      w_win_idx;
  logic [LEN_WIDTH-1:0]  w_win_len_raw;
  logic [LEN_WIDTH-1:0]  w_win_len;
  logic [DATA_WIDTH-1:0] w_cur;
  logic                  w_cur_tail;
  logic                  w_grant;
  logic                  w_xfer;
  logic                  w_release;
  logic                  w_err;

  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_slice
    assign w_flit[gi]   = bus.in_data[gi*DATA_WIDTH +: DATA_WIDTH];
    assign w_is_hdr[gi] = (w_flit[gi][DATA_WIDTH-TYPE_MSB -: TYPE_W] == FT_HEADER);
  end

  // Only a FIFO whose head is a header may start a packet here.
  assign w_elig = bus.req & bus.in_valid & ~IN_MASK & w_is_hdr;

  noc_rr_pick #(
    .N     (NUM_IN),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_req (w_elig),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_win_idx)
  );

  // A zero length field is treated as a single-flit packet.
  assign w_win_len_raw = w_flit[w_win_idx][DATA_WIDTH-LEN_MSB -: LEN_WIDTH];
  assign w_win_len     = (w_win_len_raw == '0) ? LEN_ONE : w_win_len_raw;

  assign w_cur      = w_flit[r_owner];
  assign w_cur_tail = (w_cur[DATA_WIDTH-TYPE_MSB -: TYPE_W] == FT_TAIL);

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_xfer      = 1'b0;
    w_release   = 1'b0;
    w_err       = 1'b0;
    w_rd_en     = '0;
    case (r_state)
      IDLE: begin
        if (|w_gnt) begin
          w_grant     = 1'b1;
          w_state_nxt = XFER;
        end
      end
      XFER: begin
        if (bus.in_valid[r_owner] && bus.DCTS) begin
          w_xfer           = 1'b1;
          w_rd_en[r_owner] = 1'b1;
          if (w_cur_tail || (r_cnt == LEN_ONE)) begin
            w_release   = 1'b1;
            w_state_nxt = IDLE;
            // Early tail, or the count ran out on a non-tail flit that is not
            // the header of a single-flit packet.
            w_err = (w_cur_tail && (r_cnt != LEN_ONE)) ||
                    (!w_cur_tail && !r_first);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Stage boundary: FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Stage boundary: grant bookkeeping and registered output flit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tx    <= '0;
      r_rts   <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
      r_first <= 1'b0;
      r_owner <= '0;
      r_ptr   <= IDX_W'(NUM_IN - 1);
      r_cnt   <= '0;
    end else begin
      r_rts <= w_xfer;
      r_err <= w_err;
      if (w_xfer) begin
        r_tx    <= w_cur;
        r_cnt   <= r_cnt - LEN_ONE;
        r_first <= 1'b0;
      end
      if (w_grant) begin
        r_owner <= w_win_idx;
        r_busy  <= 1'b1;
        r_cnt   <= w_win_len;
        r_first <= 1'b1;
      end
      // The released owner becomes the pointer, so it has lowest priority next.
      if (w_release) begin
        r_busy <= 1'b0;
        r_ptr  <= r_owner;
      end
    end
  end

  assign bus.rd_en   = w_rd_en;
  assign bus.TX      = r_tx;
  assign bus.RTS     = r_rts;
  assign bus.busy    = r_busy;
  assign bus.owner   = r_owner;
  assign bus.pkt_err = r_err;

endmodule

// File: tb/tb_noc_output_port_arb.sv
// Bench for noc_output_port_arb: directed scenarios plus randomized packet
// traffic, checked against a packet-level round-robin model.
module tb_noc_output_port_arb;

  localparam int N  = 5;
  localparam int DW = 32;
  localparam int LW = 12;

  localparam logic [2:0] T_HDR  = 3'b001;
  localparam logic [2:0] T_BODY = 3'b010;
  localparam logic [2:0] T_TAIL = 3'b100;

  typedef struct {
    int          src;
    logic [DW-1:0] flit;
    bit          first;
    bit          last;
    bit          err;
  } exp_t;

  logic clk;
  logic rst;

  noc_output_port_arb_if #(.NUM_IN(N), .DATA_WIDTH(DW)) ifc ();
  noc_output_port_arb_if #(.NUM_IN(N), .DATA_WIDTH(DW)) ifm ();

  noc_output_port_arb #(
    .NUM_IN(N), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .IN_MASK(5'b00000)
  ) dut (
    .clk(clk), .rst(rst), .bus(ifc.slave)
  );

  noc_output_port_arb #(
    .NUM_IN(N), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .IN_MASK(5'b00100)
  ) dut_m (
    .clk(clk), .rst(rst), .bus(ifm.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic          dcts;
  logic [DW-1:0] last_tx;
  int            mdl_ptr;
  logic [DW-1:0] fq [N][$];
  logic [DW-1:0] mq [N][$];
  exp_t          stream [$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mk(input logic [2:0] t, input int len);
    logic [DW-1:0] f;
    f = {t, LW'(len), 17'($urandom)};
    return f;
  endfunction

  function automatic logic [2:0] ftype(input logic [DW-1:0] f);
    return f[DW-1 -: 3];
  endfunction

  function automatic int flen(input logic [DW-1:0] f);
    return int'(f[DW-4 -: LW]);
  endfunction

  // Well-formed packet of nflits flits, header carrying hdr_len.
  task automatic push_pkt(input int src, input int nflits, input int hdr_len);
    fq[src].push_back(mk(T_HDR, hdr_len));
    for (int k = 2; k <= nflits; k++)
      fq[src].push_back(mk((k == nflits) ? T_TAIL : T_BODY, $urandom_range(0, 4095)));
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      ifc.in_valid[i]          = (fq[i].size() > 0);
      ifc.in_data[i*DW +: DW]  = (fq[i].size() > 0) ? fq[i][0] : '0;
    end
    ifc.req  = ifc.in_valid;
    ifc.DCTS = dcts;
  endtask

  task automatic pop(input logic [N-1:0] m);
    for (int i = 0; i < N; i++)
      if (m[i] && fq[i].size() > 0) void'(fq[i].pop_front());
  endtask

  // Packet-level model: whole packets leave the port one after another, each
  // chosen round-robin among inputs whose head is a header, the previous
  // winner ranking last. A packet ends at its tail or after `length` flits.
  task automatic build_stream();
    exp_t          e;
    int            w, len, n, j;
    logic [DW-1:0] f;
    bit            done, tail;
    stream.delete();
    for (int i = 0; i < N; i++) mq[i] = fq[i];
    forever begin
      w = -1;
      for (int k = 1; k <= N; k++) begin
        j = (mdl_ptr + k) % N;
        if (w < 0 && mq[j].size() > 0 && ftype(mq[j][0]) == T_HDR) w = j;
      end
      if (w < 0) break;
      len = flen(mq[w][0]);
      if (len == 0) len = 1;
      n    = 0;
      done = 1'b0;
      while (!done && mq[w].size() > 0) begin
        f       = mq[w].pop_front();
        n++;
        tail    = (ftype(f) == T_TAIL);
        done    = tail || (n == len);
        e.src   = w;
        e.flit  = f;
        e.first = (n == 1);
        e.last  = done;
        e.err   = done && ((tail && n < len) || (!tail && len > 1));
        stream.push_back(e);
      end
      mdl_ptr = w;
    end
  endtask

  // mode 0: DCTS always high (exact timing checked)
  // mode 1: DCTS random
  // mode 2: DCTS low for cycles 4..7
  task automatic run_stream(input int mode, input int budget);
    int            rd_i, tx_i, cyc, last_rd;
    logic          prev_rd;
    logic [N-1:0]  rdm, exp_rd;
    rd_i = 0; tx_i = 0; cyc = 0; last_rd = 0; prev_rd = 1'b0;
    build_stream();
    while ((rd_i < stream.size() || tx_i < stream.size()) && cyc < budget) begin
      case (mode)
        0:       dcts = 1'b1;
        1:       dcts = ($urandom_range(0, 9) < 7);
        default: dcts = !(cyc >= 4 && cyc < 8);
      endcase
      drive();
      @(negedge clk);
      rdm = ifc.rd_en;
      check_eq("rts_after_rd", ifc.RTS, prev_rd);
      if (ifc.RTS && tx_i < stream.size()) begin
        check_eq("tx_flit", ifc.TX, stream[tx_i].flit);
        check_eq("pkt_err", ifc.pkt_err, stream[tx_i].last && stream[tx_i].err);
        last_tx = ifc.TX;
        tx_i++;
      end else begin
        check_eq("tx_hold", ifc.TX, last_tx);
        check_eq("pkt_err_quiet", ifc.pkt_err, 0);
      end
      if (!dcts) begin
        check_eq("rd_in_stall", rdm, 0);
      end else if (rdm != 0) begin
        if (rd_i < stream.size()) begin
          exp_rd = '0;
          exp_rd[stream[rd_i].src] = 1'b1;
          check_eq("rd_en_owner", rdm, exp_rd);
          check_eq("busy_in_xfer", ifc.busy, 1);
          check_eq("owner", ifc.owner, stream[rd_i].src);
          if (mode == 0) begin
            if (rd_i == 0) check_eq("first_latency", cyc, 1);
            else check_eq("rd_spacing", cyc - last_rd, stream[rd_i].first ? 2 : 1);
          end else if (rd_i > 0 && stream[rd_i].first) begin
            check_eq("bubble", (cyc - last_rd) >= 2, 1);
          end
          last_rd = cyc;
          rd_i++;
        end else begin
          check_eq("rd_extra", rdm, 0);
        end
      end
      prev_rd = (rdm != 0);
      @(posedge clk); #1;
      pop(rdm);
      cyc++;
    end
    check_eq("stream_done", (rd_i == stream.size()) && (tx_i == stream.size()), 1);
    dcts = 1'b1;
    drive();
    @(negedge clk);
    check_eq("busy_after", ifc.busy, 0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst  = 1'b0;
    dcts = 1'b0;
    for (int i = 0; i < N; i++) fq[i].delete();
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst     = 1'b1;
    mdl_ptr = N - 1;
    last_tx = '0;
    @(negedge clk);
    check_eq("rst_tx", ifc.TX, 0);
    check_eq("rst_rts", ifc.RTS, 0);
    check_eq("rst_rd_en", ifc.rd_en, 0);
    check_eq("rst_busy", ifc.busy, 0);
    check_eq("rst_owner", ifc.owner, 0);
    check_eq("rst_pkt_err", ifc.pkt_err, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int seen, cyc, nf, hl;
    logic [N-1:0] rdm;

    ifm.req = '0; ifm.in_valid = '0; ifm.in_data = '0; ifm.DCTS = 1'b1;

    // Reset values, then a single 3-flit packet on input 2.
    do_reset();
    push_pkt(2, 3, 3);
    run_stream(0, 50);

    // Inputs 0,1,3 together (2 flits each), plus a second packet on 0.
    do_reset();
    push_pkt(0, 2, 2);
    push_pkt(1, 2, 2);
    push_pkt(3, 2, 2);
    push_pkt(0, 2, 2);
    run_stream(0, 80);

    // Downstream stall for 4 cycles in the middle of a 4-flit packet.
    do_reset();
    push_pkt(1, 4, 4);
    run_stream(2, 60);

    // Malformed packets: early tail, and count exhausted on a body flit.
    do_reset();
    fq[0].push_back(mk(T_HDR, 4));
    fq[0].push_back(mk(T_TAIL, 0));
    fq[3].push_back(mk(T_HDR, 2));
    fq[3].push_back(mk(T_BODY, 0));
    run_stream(0, 60);

    // Masked input 2 on the second instance is never granted; input 1 is.
    ifm.in_data            = '0;
    ifm.in_data[2*DW +: DW] = mk(T_HDR, 1);
    ifm.req      = 5'b00100;
    ifm.in_valid = 5'b00100;
    ifm.DCTS     = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check_eq("mask_busy", ifm.busy, 0);
      check_eq("mask_rd_en", ifm.rd_en, 0);
      @(posedge clk); #1;
    end
    ifm.in_data[1*DW +: DW] = mk(T_HDR, 1);
    ifm.req      = 5'b00110;
    ifm.in_valid = 5'b00110;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("mask_other_rd", ifm.rd_en, 5'b00010);
    @(posedge clk); #1;
    ifm.req      = 5'b00100;
    ifm.in_valid = 5'b00100;

    // Reset during flit 2 of a 5-flit packet, then a fresh request from 0.
    do_reset();
    push_pkt(2, 5, 5);
    seen = 0;
    cyc  = 0;
    dcts = 1'b1;
    while (seen < 2 && cyc < 20) begin
      drive();
      @(negedge clk);
      rdm = ifc.rd_en;
      if (rdm != 0) seen++;
      if (seen == 2) rst = 1'b0;
      @(posedge clk); #1;
      pop(rdm);
      cyc++;
    end
    check_eq("rst_flit2_seen", seen, 2);
    @(negedge clk);
    check_eq("midrst_tx", ifc.TX, 0);
    check_eq("midrst_rts", ifc.RTS, 0);
    check_eq("midrst_busy", ifc.busy, 0);
    rst = 1'b1;
    for (int i = 0; i < N; i++) fq[i].delete();
    mdl_ptr = N - 1;
    last_tx = '0;
    drive();
    @(posedge clk); #1;
    push_pkt(4, 2, 2);
    push_pkt(0, 2, 2);
    run_stream(0, 60);

    // Randomized traffic with random downstream back-pressure.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) begin
        for (int p = $urandom_range(0, 3); p > 0; p--) begin
          nf = $urandom_range(1, 4);
          hl = (nf == 1 && $urandom_range(0, 1) == 1) ? 0 : nf;
          push_pkt(i, nf, hl);
        end
      end
      run_stream(1, 600);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
